// File: rtl/reg_bank_32x32.sv
// Register bank of NREG registers, each W bits wide, with one byte-masked write port per cycle.
// Every register is presented in parallel on q. Per-register dirty bits and a write counter are also provided.
module reg_bank_32x32 #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [W-1:0]        wdata,
    input  logic [W/8-1:0]      be,
    input  logic                clr,
    output logic [NREG*W-1:0]   q,
    output logic [NREG-1:0]     dirty,
    output logic [15:0]         wr_count
);

    logic [W-1:0]  regs_q [NREG];
    logic [W-1:0]  regs_d [NREG];
    logic [NREG-1:0] dirty_q, dirty_d;
    logic [15:0]   wr_count_q, wr_count_d;
    logic          wr_accept;

    assign wr_accept = we && (waddr != '0) && (be != '0) && !clr;

    always_comb begin
        regs_d     = regs_q;
        dirty_d    = dirty_q;
        wr_count_d = wr_count_q;
        if (clr) begin
            for (int k = 0; k < NREG; k++) regs_d[k] = '0;
            dirty_d    = '0;
            wr_count_d = '0;
        end else if (wr_accept) begin
            for (int b = 0; b < W/8; b++) begin
                if (be[b]) regs_d[waddr][8*b +: 8] = wdata[8*b +: 8];
            end
            dirty_d[waddr] = 1'b1;
            wr_count_d     = wr_count_q + 16'd1;
        end
        // Register 0 is hardwired to zero regardless of any write.
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
            dirty_q    <= '0;
            wr_count_q <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= regs_d[k];
            dirty_q    <= dirty_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        q = '0;
        for (int k = 1; k < NREG; k++) q[W*k +: W] = regs_q[k];
    end

    assign dirty    = dirty_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Directed testbench for reg_bank_32x32.
// Each step applies one set of inputs, waits for a clock edge and checks the result against hand-computed values.
module tb_reg_bank_32x32;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int W    = 32;

    logic                clk;
    logic                rst_n;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [W-1:0]        wdata;
    logic [W/8-1:0]      be;
    logic                clr;
    logic [NREG*W-1:0]   q;
    logic [NREG-1:0]     dirty;
    logic [15:0]         wr_count;

    int check_count = 0;
    int error_count = 0;
    logic [31:0] exp_reg [NREG];

    reg_bank_32x32 #(.NREG(NREG), .AW(AW), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .be(be), .clr(clr), .q(q), .dirty(dirty), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slice(input int k);
        return q[W*k +: W];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then return to idle 1 time unit after the rising edge.
    task automatic applyStimulus(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                                 input logic [W/8-1:0] b, input logic c);
        we = w; waddr = a; wdata = d; be = b; clr = c;
        @(posedge clk);
        #1;
        we = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b1; waddr = 5'd6; wdata = $urandom; be = 4'hF; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_q_ones", $countones(q), 32'd0);
        checkOutput("reset_dirty", dirty, 32'h0);
        checkOutput("reset_count", {16'h0, wr_count}, 32'h0);

        // First rising edge after release accepts the pending write.
        @(negedge clk);
        wdata = 32'hCAFEF00D;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        checkOutput("first_write_reg6", slice(6), 32'hCAFEF00D);
        checkOutput("first_write_dirty", dirty, 32'h0000_0040);
        checkOutput("first_write_count", {16'h0, wr_count}, 32'd1);

        // Mid-cycle reset with a write pending must clear everything immediately.
        we = 1'b1; waddr = 5'd8; wdata = 32'h55AA55AA; be = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_q_ones", $countones(q), 32'd0);
        checkOutput("async_reset_dirty", dirty, 32'h0);
        checkOutput("async_reset_count", {16'h0, wr_count}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("held_reset_q_ones", $countones(q), 32'd0);
        checkOutput("held_reset_count", {16'h0, wr_count}, 32'h0);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;

        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0);
        checkOutput("full_write_reg5", slice(5), 32'hDEADBEEF);
        checkOutput("full_write_dirty", dirty, 32'h0000_0020);
        checkOutput("full_write_count", {16'h0, wr_count}, 32'd1);
        checkOutput("full_write_q_ones", $countones(q), 32'd24);

        applyStimulus(1'b1, 5'd7, 32'h11223344, 4'hF, 1'b0);
        checkOutput("lane_setup_reg7", slice(7), 32'h11223344);
        applyStimulus(1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 1'b0);
        checkOutput("lane_mask_reg7", slice(7), 32'h11BB33DD);
        checkOutput("lane_mask_count", {16'h0, wr_count}, 32'd3);
        applyStimulus(1'b1, 5'd7, 32'hFFFFFFFF, 4'h0, 1'b0);
        checkOutput("be_zero_reg7", slice(7), 32'h11BB33DD);
        checkOutput("be_zero_count", {16'h0, wr_count}, 32'd3);
        applyStimulus(1'b1, 5'd10, 32'hFFFFFFFF, 4'h0, 1'b0);
        checkOutput("be_zero_dirty", dirty, 32'h0000_00A0);

        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0);
        checkOutput("reg0_value", slice(0), 32'h0);
        checkOutput("reg0_dirty", dirty, 32'h0000_00A0);
        checkOutput("reg0_count", {16'h0, wr_count}, 32'd3);

        applyStimulus(1'b0, 5'd5, 32'h01234567, 4'hF, 1'b0);
        checkOutput("we_low_reg5", slice(5), 32'hDEADBEEF);
        checkOutput("we_low_count", {16'h0, wr_count}, 32'd3);

        applyStimulus(1'b1, 5'd3, 32'h12345678, 4'hF, 1'b0);
        checkOutput("clr_setup_reg3", slice(3), 32'h12345678);
        applyStimulus(1'b1, 5'd9, 32'h87654321, 4'hF, 1'b1);
        checkOutput("clr_q_ones", $countones(q), 32'd0);
        checkOutput("clr_dirty", dirty, 32'h0);
        checkOutput("clr_count", {16'h0, wr_count}, 32'h0);

        // Counter wrap: 65536 accepted writes cycling through registers 1..31.
        for (int k = 0; k < NREG; k++) exp_reg[k] = 32'h0;
        for (int i = 0; i < 65536; i++) begin
            logic [AW-1:0] a;
            logic [31:0]   d;
            a = AW'(1 + (i % 31));
            d = {i[15:0], ~i[15:0]} ^ 32'h5A5A0000;
            exp_reg[a] = d;
            applyStimulus(1'b1, a, d, 4'hF, 1'b0);
            if (i == 65534) checkOutput("count_max", {16'h0, wr_count}, 32'h0000FFFF);
        end
        checkOutput("count_wrap", {16'h0, wr_count}, 32'h0);
        checkOutput("wrap_dirty", dirty, 32'hFFFF_FFFE);
        for (int k = 0; k < NREG; k++) begin
            checkOutput($sformatf("wrap_reg%0d", k), slice(k), exp_reg[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
